// File: rtl/aprop_hub_pkg.sv
// ============================================================================
// Package   : aprop_pkg
// Purpose   : Shared types and defaults for the AProp hub memory arbiter.
//             Holds the access-size encoding, default cog count, default hub
//             byte-address width and a byte-enable helper.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package aprop_pkg;

  localparam int DEFAULT_COGS   = 8;
  localparam int DEFAULT_ADDR_W = 15;

  // Access size; the reserved code behaves exactly like a long.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_LONG = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Byte enables for an already-aligned lane offset.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << lane;
      SZ_WORD: lane_be = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/aprop_hub_if.sv
// ============================================================================
// Interface : aprop_hub_if
// Purpose   : Bundles every cog's hub-access port with the shared return path.
// Ports     : req_in/we_in/size_in/addr_in/wdata_in - per-cog request fields,
//             packed cog-major (cog i at [i*W +: W]).
//             rdata_out/ack_out/slot_out - shared hub responses.
//             master = cog side, slave = hub side.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aprop_hub_if
  import aprop_pkg::*;
#(
  parameter int COGS   = DEFAULT_COGS,
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  localparam int SW = $clog2(COGS);

  logic [COGS-1:0]        req_in;
  logic [COGS-1:0]        we_in;
  logic [2*COGS-1:0]      size_in;
  logic [ADDR_W*COGS-1:0] addr_in;
  logic [32*COGS-1:0]     wdata_in;
  logic [31:0]            rdata_out;
  logic [COGS-1:0]        ack_out;
  logic [SW-1:0]          slot_out;

  modport master (
    output req_in, we_in, size_in, addr_in, wdata_in,
    input  rdata_out, ack_out, slot_out
  );

  modport slave (
    input  req_in, we_in, size_in, addr_in, wdata_in,
    output rdata_out, ack_out, slot_out
  );

endinterface

`default_nettype wire

// File: rtl/aprop_hub_ram.sv
// ============================================================================
// Module    : aprop_hub_ram
// Purpose   : Single-port hub RAM, MEM_LONGS x 32, byte-enable write,
//             registered read. Isolated so a vendor block RAM can replace it.
// Ports     : clk_in - clock; en - access strobe; we - write when en;
//             be - byte lane enables; addr - long address;
//             wdata - lane-replicated write data; rdata - registered read data.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module aprop_hub_ram #(
  parameter int MEM_LONGS = 8192,
  parameter int AW        = $clog2(MEM_LONGS)
) (
  input  wire logic          clk_in,
  input  wire logic          en,
  input  wire logic          we,
  input  wire logic [3:0]    be,
  input  wire logic [AW-1:0] addr,
  input  wire logic [31:0]   wdata,
  output logic [31:0]        rdata
);

  logic [31:0] r_mem [MEM_LONGS];

  always_ff @(posedge clk_in) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= r_mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/aprop_hub.sv
// ============================================================================
// Module    : aprop_hub
// Purpose   : Round-robin hub memory arbiter. Each cog owns a two-cycle slot:
//             a sample phase that issues the RAM access and a complete phase
//             that returns ack and right-aligned, zero-extended read data.
// Ports     : clk_in   - system clock
//             reset_in - synchronous, active-low reset
//             bus      - aprop_hub_if.slave (cog requests, shared responses)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module aprop_hub
  import aprop_pkg::*;
#(
  parameter int COGS      = DEFAULT_COGS,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MEM_LONGS = 8192
) (
  input wire logic   clk_in,
  input wire logic   reset_in,
  aprop_hub_if.slave bus
);

  localparam int SW = $clog2(COGS);

  // cnt[0] is the phase (0 sample, 1 complete); upper bits are the owner.
  logic [SW:0]       r_cnt;
  logic              r_issued;
  logic              r_we;
  logic [1:0]        r_size;
  logic [1:0]        r_lane;

  logic [SW-1:0]     w_slot;
  logic              w_phase;
  logic [ADDR_W-1:0] w_addr  [COGS];
  logic [1:0]        w_size  [COGS];
  logic [31:0]       w_wdata [COGS];

  logic [ADDR_W-1:0] w_sel_addr;
  logic [1:0]        w_sel_size;
  logic [31:0]       w_sel_wdata;
  logic [1:0]        w_lane;
  logic              w_issue;
  logic [3:0]        w_be;
  logic [31:0]       w_ram_wdata;
  logic [31:0]       w_ram_q;
  logic [31:0]       w_shift;
  logic [31:0]       w_rdata;
  logic [COGS-1:0]   w_ack;

  assign w_slot  = r_cnt[SW:1];
  assign w_phase = r_cnt[0];

  for (genvar i = 0; i < COGS; i++) begin : g_unpack
    assign w_addr[i]  = bus.addr_in[i*ADDR_W +: ADDR_W];
    assign w_size[i]  = bus.size_in[2*i +: 2];
    assign w_wdata[i] = bus.wdata_in[32*i +: 32];
  end

  // Request decode for the owning cog; alignment and lane replication.
  always_comb begin
    w_sel_addr  = w_addr[w_slot];
    w_sel_size  = w_size[w_slot];
    w_sel_wdata = w_wdata[w_slot];
    w_lane      = 2'b00;
    w_ram_wdata = w_sel_wdata;
    case (w_sel_size)
      SZ_BYTE: begin
        w_lane      = w_sel_addr[1:0];
        w_ram_wdata = {4{w_sel_wdata[7:0]}};
      end
      SZ_WORD: begin
        w_lane      = {w_sel_addr[1], 1'b0};
        w_ram_wdata = {2{w_sel_wdata[15:0]}};
      end
      default: ;
    endcase
    w_be    = lane_be(w_sel_size, w_lane);
    // Gating with reset keeps an in-flight access from being issued.
    w_issue = reset_in & ~w_phase & bus.req_in[w_slot];
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_cnt    <= '0;
      r_issued <= 1'b0;
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_lane   <= 2'b00;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
      r_issued <= w_issue;
      if (w_issue) begin
        r_we   <= bus.we_in[w_slot];
        r_size <= w_sel_size;
        r_lane <= w_lane;
      end
    end
  end

  aprop_hub_ram #(
    .MEM_LONGS (MEM_LONGS)
  ) u_ram (
    .clk_in (clk_in),
    .en     (w_issue),
    .we     (bus.we_in[w_slot]),
    .be     (w_be),
    .addr   (w_sel_addr[ADDR_W-1:2]),
    .wdata  (w_ram_wdata),
    .rdata  (w_ram_q)
  );

  // Complete phase: the slot owner is unchanged, so ack goes to w_slot.
  always_comb begin
    w_ack   = '0;
    w_rdata = '0;
    w_shift = w_ram_q >> {r_lane, 3'b000};
    if (r_issued && w_phase) begin
      w_ack[w_slot] = 1'b1;
      if (!r_we) begin
        case (r_size)
          SZ_BYTE: w_rdata = {24'h0, w_shift[7:0]};
          SZ_WORD: w_rdata = {16'h0, w_shift[15:0]};
          default: w_rdata = w_ram_q;
        endcase
      end
    end
  end

  assign bus.ack_out   = w_ack;
  assign bus.rdata_out = w_rdata;
  assign bus.slot_out  = w_slot;

endmodule

`default_nettype wire

// File: tb/tb_aprop_hub.sv
// ============================================================================
// Module    : tb_aprop_hub
// Purpose   : Directed self-checking bench for aprop_hub (8 cogs, 32 KB).
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aprop_hub;
  import aprop_pkg::*;

  localparam int COGS   = 8;
  localparam int ADDR_W = 15;

  logic clk_in;
  logic reset_in;
  logic [3:0] m_cnt;
  int n_cmp;
  int n_bad;

  aprop_hub_if #(.COGS(COGS), .ADDR_W(ADDR_W)) bus ();

  aprop_hub #(
    .COGS      (COGS),
    .ADDR_W    (ADDR_W),
    .MEM_LONGS (8192)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Expected slot counter, used only to line stimulus up with slots.
  always @(posedge clk_in) m_cnt <= reset_in ? m_cnt + 4'd1 : 4'd0;

  task automatic test_reset();
    reset_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      n_cmp++;
      if (bus.slot_out !== 3'd0 || bus.ack_out !== 8'h00 || bus.rdata_out !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_hold: slot=%0d ack=%b rdata=%h expected slot=0 ack=0 rdata=0",
                 bus.slot_out, bus.ack_out, bus.rdata_out);
      end
    end
    reset_in = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic [2:0] es;
      es = 3'((k / 2) % 8);
      @(negedge clk_in);
      n_cmp++;
      if (bus.slot_out !== es || bus.ack_out !== 8'h00 || bus.rdata_out !== 32'h0) begin
        n_bad++;
        $display("FAIL idle_step%0d: slot=%0d ack=%b rdata=%h expected slot=%0d ack=0 rdata=0",
                 k, bus.slot_out, bus.ack_out, bus.rdata_out, es);
      end
    end
  endtask

  task automatic access(input int cog, input logic we, input logic [1:0] sz,
                        input logic [14:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input string nm);
    bit found;
    logic [7:0] exp_ack;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_in);
      if (m_cnt == 4'(2 * cog)) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s_slot_wait: slot never reached, expected cnt=%0d", nm, 2 * cog);
      return;
    end
    bus.req_in[cog]            = 1'b1;
    bus.we_in[cog]             = we;
    bus.size_in[cog*2 +: 2]    = sz;
    bus.addr_in[cog*15 +: 15]  = a;
    bus.wdata_in[cog*32 +: 32] = wd;
    @(negedge clk_in);
    exp_ack = 8'h01 << cog;
    n_cmp++;
    if (bus.ack_out !== exp_ack) begin
      n_bad++;
      $display("FAIL %s_ack: got %b expected %b", nm, bus.ack_out, exp_ack);
    end
    n_cmp++;
    if (bus.rdata_out !== exp_rd) begin
      n_bad++;
      $display("FAIL %s_rdata: got %h expected %h", nm, bus.rdata_out, exp_rd);
    end
    n_cmp++;
    if (bus.slot_out !== 3'(cog)) begin
      n_bad++;
      $display("FAIL %s_slot: got %0d expected %0d", nm, bus.slot_out, cog);
    end
    bus.req_in[cog] = 1'b0;
    bus.we_in[cog]  = 1'b0;
  endtask

  task automatic test_long_rw();
    access(3, 1'b1, SZ_LONG, 15'h0100, 32'hDEADBEEF, 32'h0, "c3_long_wr");
    access(3, 1'b0, SZ_LONG, 15'h0100, 32'h0, 32'hDEADBEEF, "c3_long_rd");
  endtask

  task automatic test_lanes();
    access(1, 1'b1, SZ_BYTE, 15'h0102, 32'hFFFFFF55, 32'h0, "c1_byte_wr");
    access(5, 1'b0, SZ_LONG, 15'h0100, 32'h0, 32'hDE55BEEF, "c5_long_rd");
    access(2, 1'b0, SZ_WORD, 15'h0103, 32'h0, 32'h0000DE55, "c2_word_rd");
    access(7, 1'b0, SZ_BYTE, 15'h0101, 32'h0, 32'h000000BE, "c7_byte_rd");
    access(0, 1'b1, SZ_LONG, 15'h0200, 32'h11223344, 32'h0, "c0_long_wr");
    access(6, 1'b1, SZ_WORD, 15'h0203, 32'hFFFFABCD, 32'h0, "c6_word_wr_hi");
    access(4, 1'b0, SZ_RSVD, 15'h0202, 32'h0, 32'hABCD3344, "c4_rsvd_rd");
    access(4, 1'b0, SZ_WORD, 15'h0200, 32'h0, 32'h00003344, "c4_word_rd_lo");
  endtask

  task automatic test_all_cogs();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_in);
      if (m_cnt == 4'd0) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL all_slot_wait: cnt=0 never reached");
      return;
    end
    for (int c = 0; c < COGS; c++) begin
      bus.we_in[c]             = 1'b0;
      bus.size_in[c*2 +: 2]    = SZ_LONG;
      bus.addr_in[c*15 +: 15]  = 15'h0100;
    end
    bus.req_in = 8'hFF;
    for (int j = 1; j <= 16; j++) begin
      logic [7:0]  ea;
      logic [31:0] er;
      @(negedge clk_in);
      ea = (j % 2 == 1) ? (8'h01 << (j / 2)) : 8'h00;
      er = (j % 2 == 1) ? 32'hDE55BEEF : 32'h0;
      n_cmp++;
      if (bus.ack_out !== ea || bus.rdata_out !== er) begin
        n_bad++;
        $display("FAIL all_cogs_cyc%0d: ack=%b rdata=%h expected ack=%b rdata=%h",
                 j, bus.ack_out, bus.rdata_out, ea, er);
      end
      if (j % 2 == 1) bus.req_in[j/2] = 1'b0;
    end
    bus.req_in = 8'h00;
  endtask

  task automatic test_worst_wait();
    bit found;
    int n;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_in);
      if (m_cnt == 4'd1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL worst_slot_wait: cnt=1 never reached");
      return;
    end
    bus.we_in[0]        = 1'b0;
    bus.size_in[1:0]    = SZ_BYTE;
    bus.addr_in[14:0]   = 15'h0103;
    bus.req_in[0]       = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      n = k;
      if (bus.ack_out !== 8'h00) break;
    end
    n_cmp++;
    if (n != 16 || bus.ack_out !== 8'h01 || bus.rdata_out !== 32'h000000DE) begin
      n_bad++;
      $display("FAIL worst_wait: latency=%0d ack=%b rdata=%h expected latency=16 ack=00000001 rdata=000000de",
               n, bus.ack_out, bus.rdata_out);
    end
    bus.req_in[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_in);
      if (m_cnt == 4'd4) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL rstmid_slot_wait: cnt=4 never reached");
      return;
    end
    bus.we_in[2]          = 1'b0;
    bus.size_in[5:4]      = SZ_LONG;
    bus.addr_in[44:30]    = 15'h0100;
    bus.req_in[2]         = 1'b1;
    reset_in              = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      n_cmp++;
      if (bus.ack_out !== 8'h00 || bus.rdata_out !== 32'h0 || bus.slot_out !== 3'd0) begin
        n_bad++;
        $display("FAIL rstmid_hold%0d: ack=%b rdata=%h slot=%0d expected ack=0 rdata=0 slot=0",
                 k, bus.ack_out, bus.rdata_out, bus.slot_out);
      end
    end
    bus.req_in[2] = 1'b0;
    reset_in      = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      logic [2:0] es;
      es = 3'(k / 2);
      @(negedge clk_in);
      n_cmp++;
      if (bus.slot_out !== es || bus.ack_out !== 8'h00) begin
        n_bad++;
        $display("FAIL rstmid_restart%0d: slot=%0d ack=%b expected slot=%0d ack=0",
                 k, bus.slot_out, bus.ack_out, es);
      end
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset_in    = 1'b0;
    bus.req_in   = '0;
    bus.we_in    = '0;
    bus.size_in  = '0;
    bus.addr_in  = '0;
    bus.wdata_in = '0;
    test_reset();
    test_long_rw();
    test_lanes();
    test_all_cogs();
    test_worst_wait();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
